// File: rtl/pll_power_seq.sv
// PLL analog power sequencer: ordered bias -> charge pump -> VCO bring-up
// with per-stage settle timing and slew-limited trim once the VCO runs.
module pll_power_seq #(
    parameter int         BIAS_SETTLE = 16,
    parameter int         CP_SETTLE   = 8,
    parameter int         VCO_SETTLE  = 64,
    parameter int         TRIM_STEP   = 4,
    parameter logic [3:0] TRIM_RST    = 4'h8,
    parameter int         CNT_W       = 8
) (
    input  logic       SCK,
    input  logic       RST,
    input  logic       cfg_bias_ena,
    input  logic       cfg_cp_ena,
    input  logic       cfg_vco_ena,
    input  logic [3:0] cfg_trim,
    output logic       pll_bias_ena,
    output logic       pll_cp_ena,
    output logic       pll_vco_ena,
    output logic [3:0] pll_trim,
    output logic       pll_ready,
    output logic       seq_busy
);

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        BIAS = 2'd1,
        CP   = 2'd2,
        VCO  = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] BIAS_CNT = CNT_W'(BIAS_SETTLE);
    localparam logic [CNT_W-1:0] CP_CNT   = CNT_W'(CP_SETTLE);
    localparam logic [CNT_W-1:0] VCO_CNT  = CNT_W'(VCO_SETTLE);
    localparam logic [CNT_W-1:0] STEP_TOP = CNT_W'(TRIM_STEP - 1);

    state_e           state;
    state_e           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] tcnt;
    logic [CNT_W-1:0] tcnt_nxt;
    logic [3:0]       trim_nxt;
    logic [1:0]       target;
    logic [1:0]       level;
    logic             settled;
    logic             trim_eq;

    // Requests for later stages count only when their predecessors are on.
    always_comb begin
        target = 2'd0;
        if (cfg_bias_ena) begin
            target = 2'd1;
            if (cfg_cp_ena) begin
                target = 2'd2;
                if (cfg_vco_ena) target = 2'd3;
            end
        end
    end

    assign level   = state;
    assign settled = (cnt == '0);
    assign trim_eq = (pll_trim == cfg_trim);

    always_ff @(posedge SCK or posedge RST) begin
        if (RST) begin
            state    <= OFF;
            cnt      <= '0;
            tcnt     <= '0;
            pll_trim <= TRIM_RST;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            tcnt     <= tcnt_nxt;
            pll_trim <= trim_nxt;
        end
    end

    // Dropping a request wins over any settle in progress.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (target < level) begin
            state_nxt = state_e'(level - 2'd1);
            cnt_nxt   = '0;
        end else if (target > level && settled) begin
            state_nxt = state_e'(level + 2'd1);
            unique case (state)
                OFF:     cnt_nxt = BIAS_CNT;
                BIAS:    cnt_nxt = CP_CNT;
                default: cnt_nxt = VCO_CNT;
            endcase
        end else if (!settled) begin
            cnt_nxt = cnt - 1'b1;
        end
    end

    // Trim tracks directly until the VCO runs, then slews one code per step.
    always_comb begin
        trim_nxt = pll_trim;
        tcnt_nxt = tcnt;
        if (state != VCO) begin
            trim_nxt = cfg_trim;
            tcnt_nxt = '0;
        end else if (trim_eq) begin
            tcnt_nxt = '0;
        end else if (tcnt == STEP_TOP) begin
            tcnt_nxt = '0;
            if (cfg_trim > pll_trim) trim_nxt = pll_trim + 4'd1;
            else                     trim_nxt = pll_trim - 4'd1;
        end else begin
            tcnt_nxt = tcnt + 1'b1;
        end
    end

    always_comb begin
        pll_bias_ena = (state != OFF);
        pll_cp_ena   = (state == CP) || (state == VCO);
        pll_vco_ena  = (state == VCO);
        pll_ready    = (state == VCO) && settled && trim_eq
                       && (target == 2'd3);
        seq_busy     = (level != target) || !settled
                       || ((state == VCO) && !trim_eq);
    end

endmodule

// File: tb/tb_pll_power_seq.sv
// Directed bench for pll_power_seq: bring-up timing, ordered shutdown,
// trim slewing, ignored requests and asynchronous reset mid-sequence.
module tb_pll_power_seq;

    logic       SCK;
    logic       RST;
    logic       cfg_bias_ena;
    logic       cfg_cp_ena;
    logic       cfg_vco_ena;
    logic [3:0] cfg_trim;
    logic       pll_bias_ena;
    logic       pll_cp_ena;
    logic       pll_vco_ena;
    logic [3:0] pll_trim;
    logic       pll_ready;
    logic       seq_busy;

    int checks;
    int errors;

    pll_power_seq dut (
        .SCK          (SCK),
        .RST          (RST),
        .cfg_bias_ena (cfg_bias_ena),
        .cfg_cp_ena   (cfg_cp_ena),
        .cfg_vco_ena  (cfg_vco_ena),
        .cfg_trim     (cfg_trim),
        .pll_bias_ena (pll_bias_ena),
        .pll_cp_ena   (pll_cp_ena),
        .pll_vco_ena  (pll_vco_ena),
        .pll_trim     (pll_trim),
        .pll_ready    (pll_ready),
        .seq_busy     (seq_busy)
    );

    initial SCK = 1'b0;
    always #5 SCK = ~SCK;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge SCK);
        #1;
    endtask

    task automatic check_ena(input string tag, input logic [2:0] exp);
        check(tag, {pll_vco_ena, pll_cp_ena, pll_bias_ena}, exp);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        RST          = 1'b1;
        cfg_bias_ena = 1'b0;
        cfg_cp_ena   = 1'b0;
        cfg_vco_ena  = 1'b0;
        cfg_trim     = 4'd3;

        // reset state
        repeat (3) tick();
        check_ena("rst_ena", 3'b000);
        check("rst_trim", pll_trim, 4'h8);
        check("rst_ready", pll_ready, 1'b0);
        check("rst_busy", seq_busy, 1'b0);
        RST = 1'b0;
        repeat (2) tick();
        check("idle_trim", pll_trim, 4'd3);
        check("idle_busy", seq_busy, 1'b0);

        // full bring-up; edge E is the first tick below
        cfg_bias_ena = 1'b1;
        cfg_cp_ena   = 1'b1;
        cfg_vco_ena  = 1'b1;
        tick();
        check_ena("up_e", 3'b001);
        check("up_e_busy", seq_busy, 1'b1);
        for (int i = 1; i <= 16; i++) begin
            tick();
            check_ena("up_bias_hold", 3'b001);
        end
        tick();
        check_ena("up_e17", 3'b011);
        repeat (8) tick();
        check_ena("up_e25", 3'b011);
        tick();
        check_ena("up_e26", 3'b111);
        check("up_e26_ready", pll_ready, 1'b0);
        repeat (63) tick();
        check("up_e89_ready", pll_ready, 1'b0);
        check("up_e89_busy", seq_busy, 1'b1);
        tick();
        check("up_e90_ready", pll_ready, 1'b1);
        check("up_e90_busy", seq_busy, 1'b0);

        // trim slew 3 -> 7
        cfg_trim = 4'd7;
        #1;
        check("slew_ready0", pll_ready, 1'b0);
        check("slew_busy0", seq_busy, 1'b1);
        for (int s = 1; s <= 4; s++) begin
            repeat (3) tick();
            check("slew_hold", pll_trim, 4'(2 + s));
            check("slew_busy", seq_busy, 1'b1);
            tick();
            check("slew_step", pll_trim, 4'(3 + s));
            check("slew_ready", pll_ready, (s == 4) ? 1'b1 : 1'b0);
        end
        tick();
        check("slew_done", pll_trim, 4'd7);

        // ordered shutdown
        cfg_bias_ena = 1'b0;
        #1;
        check("dn_ready0", pll_ready, 1'b0);
        tick();
        check_ena("dn_1", 3'b011);
        tick();
        check_ena("dn_2", 3'b001);
        tick();
        check_ena("dn_3", 3'b000);
        check("dn_busy", seq_busy, 1'b0);

        // cp/vco without bias are ignored
        cfg_cp_ena  = 1'b1;
        cfg_vco_ena = 1'b1;
        repeat (20) tick();
        check_ena("nobias", 3'b000);
        check("nobias_busy", seq_busy, 1'b0);

        // async reset in the middle of charge-pump settle
        cfg_bias_ena = 1'b1;
        tick();
        repeat (17) tick();
        repeat (3) tick();
        check_ena("pre_rst", 3'b011);
        RST = 1'b1;
        #1;
        check_ena("mid_rst", 3'b000);
        check("mid_rst_trim", pll_trim, 4'h8);
        repeat (2) tick();
        RST = 1'b0;
        tick();
        check_ena("re_e", 3'b001);
        repeat (16) tick();
        check_ena("re_e16", 3'b001);
        tick();
        check_ena("re_e17", 3'b011);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
